// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: an oversampling UART receiver followed by a first-word-fall-through FIFO.
// The data width, parity mode, stop-bit count and FIFO depth are all parameters.
// Parity, framing and overrun errors are reported on sticky flags that clear_err_i clears.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overrun_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  input  logic                          clear_err_i
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic          ODD_INV     = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   stop_bad_q, stop_bad_d;
  logic                   push_q, push_d;
  logic [DATA_BITS-1:0]   push_data_q, push_data_d;
  logic                   frame_set, parity_set;
  logic                   overrun_q, overrun_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic                   rxs, tick, exp_par;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic                   pop, push_ok, full;

  assign rxs     = sync2_q;
  assign tick    = (cnt_q == '0);
  assign exp_par = (^shift_q) ^ ODD_INV;

  // Two-flop synchroniser plus the edge-detect history; idle-high line, history resets low
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      stop_bad_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      stop_bad_q  <= stop_bad_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // Receiver next state: a baud countdown drives each mid-bit sample; the frame is judged at the last stop sample
  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? cnt_q : cnt_q - 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    stop_bad_d  = stop_bad_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_set   = 1'b0;
    parity_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (prev_q && !rxs) begin
          cnt_d   = HALF_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs) begin
            cnt_d   = BIT_RELOAD;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d      = '0;
            stop_bad_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          par_d   = rxs;
          cnt_d   = BIT_RELOAD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            if (stop_bad_q || !rxs) begin
              frame_set = 1'b1;
            end else if ((PARITY != 0) && (par_q != exp_par)) begin
              parity_set = 1'b1;
            end else begin
              push_d      = 1'b1;
              push_data_d = shift_q;
            end
          end else begin
            bit_d      = bit_q + 1'b1;
            stop_bad_d = stop_bad_q | ~rxs;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign push_ok = push_q & (~full | pop);
  assign data_o  = valid_o ? mem[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_q;
  end

  // FIFO pointers and occupancy; power-of-two depth makes the pointers wrap naturally
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // Sticky flag next values: a set in the same cycle as a clear wins
  always_comb begin
    overrun_d    = (push_q & ~push_ok) | (overrun_q    & ~clear_err_i);
    parity_err_d = parity_set          | (parity_err_q & ~clear_err_i);
    frame_err_d  = frame_set           | (frame_err_q  & ~clear_err_i);
  end

  // Sticky flag registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign overrun_o    = overrun_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;

endmodule
